// File: rtl/debounce_pkg.sv
// Shared defaults and the debounced channel-state encoding for debounce_multi.
package debounce_pkg;

    localparam int DEF_NUM_CH        = 4;
    localparam int DEF_STABLE_CYCLES = 8;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_PB_ACTIVE_LOW = 0;
    localparam int DEF_LONG_CYCLES   = 32;

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } pb_state_e;

endpackage

// File: rtl/debounce_ch.sv
// One push-button channel: synchroniser, stability counter, press/release pulses.
// Long-press detection is built only when DEBOUNCE_LONG_PRESS_EN is defined.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int PB_ACTIVE_LOW = DEF_PB_ACTIVE_LOW,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES
) (
    input  logic i_clk,
    input  logic i_async_reset_n,
    input  logic i_pb,
    output logic o_pb_clean,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int              CNT_W        = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
    localparam logic            RELEASED_PIN = (PB_ACTIVE_LOW != 0);

    if (STABLE_CYCLES < 2 || SYNC_STAGES < 2 || LONG_CYCLES < 1) begin : g_bad_params
        $error("debounce_ch: STABLE_CYCLES>=2, SYNC_STAGES>=2, LONG_CYCLES>=1 required");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    pb_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;

    // NOTE: the synchroniser is reset to the pin's released level, so leaving
    // reset can never look like a press arriving through the pipeline.
    always_ff @(posedge i_clk or negedge i_async_reset_n) begin
        if (!i_async_reset_n) begin
            sync_q <= {SYNC_STAGES{RELEASED_PIN}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_pb};
        end
    end

    assign s = sync_q[SYNC_STAGES-1] ^ RELEASED_PIN;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (s != state_q) begin
            if (cnt_q == CNT_LAST) begin
                state_d   = s ? PRESSED : RELEASED;
                press_d   = s;
                release_d = ~s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_async_reset_n) begin
        if (!i_async_reset_n) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign o_pb_clean = (state_q == PRESSED);
    assign o_press    = press_q;
    assign o_release  = release_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int               HOLD_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q;
    logic              long_q;

    // Counts cycles spent pressed; saturating stops the pulse from repeating.
    always_ff @(posedge i_clk or negedge i_async_reset_n) begin
        if (!i_async_reset_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            long_q <= (state_q == PRESSED) && (hold_q == HOLD_LAST);
            if (state_q == RELEASED) begin
                hold_q <= '0;
            end else if (hold_q != HOLD_MAX) begin
                hold_q <= hold_q + HOLD_W'(1);
            end
        end
    end

    assign o_long = long_q;
`else
    assign o_long = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// NUM_CH independent debounced push-button channels sharing one clock and reset.
// Define DEBOUNCE_LONG_PRESS_EN to enable the per-channel o_long pulse.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int NUM_CH        = DEF_NUM_CH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int PB_ACTIVE_LOW = DEF_PB_ACTIVE_LOW,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES
) (
    input  logic              i_clk,
    input  logic              i_async_reset_n,
    input  logic [NUM_CH-1:0] i_pb,
    output logic [NUM_CH-1:0] o_pb_clean,
    output logic [NUM_CH-1:0] o_press,
    output logic [NUM_CH-1:0] o_release,
    output logic [NUM_CH-1:0] o_long
);

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        debounce_ch #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES),
            .PB_ACTIVE_LOW (PB_ACTIVE_LOW),
            .LONG_CYCLES   (LONG_CYCLES)
        ) u_ch (
            .i_clk           (i_clk),
            .i_async_reset_n (i_async_reset_n),
            .i_pb            (i_pb[n]),
            .o_pb_clean      (o_pb_clean[n]),
            .o_press         (o_press[n]),
            .o_release       (o_release[n]),
            .o_long          (o_long[n])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: an active-high and an active-low instance
// share one window-based reference model; directed cases plus random bouncing.
module tb_debounce_multi;
    import debounce_pkg::*;

    localparam int NCH    = 4;
    localparam int STABLE = 8;
    localparam int SYNC   = 2;
    localparam int LONG   = 32;
`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int LONG_ON = 1;
`else
    localparam int LONG_ON = 0;
`endif

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] pb    = '0;
    logic [NCH-1:0] pb_n;
    logic [NCH-1:0] clean_h, press_h, rel_h, long_h;
    logic [NCH-1:0] clean_l, press_l, rel_l, long_l;

    assign pb_n = ~pb;
    always #5 clk = ~clk;

    debounce_multi #(
        .NUM_CH(NCH), .STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC),
        .PB_ACTIVE_LOW(0), .LONG_CYCLES(LONG)
    ) dut_h (
        .i_clk(clk), .i_async_reset_n(rst_n), .i_pb(pb),
        .o_pb_clean(clean_h), .o_press(press_h), .o_release(rel_h), .o_long(long_h)
    );

    debounce_multi #(
        .NUM_CH(NCH), .STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC),
        .PB_ACTIVE_LOW(1), .LONG_CYCLES(LONG)
    ) dut_l (
        .i_clk(clk), .i_async_reset_n(rst_n), .i_pb(pb_n),
        .o_pb_clean(clean_l), .o_press(press_l), .o_release(rel_l), .o_long(long_l)
    );

    typedef struct packed {
        logic [NCH-1:0] clean;
        logic [NCH-1:0] press;
        logic [NCH-1:0] rel;
        logic [NCH-1:0] lng;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_exp;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a level is accepted once the last STABLE synchronised
    // samples all disagree with the current clean level.
    logic [NCH-1:0] m_clean, m_press, m_rel, m_long;
    bit dly[NCH][$];
    bit win[NCH][$];
`ifdef DEBOUNCE_LONG_PRESS_EN
    int hold[NCH];
`endif

    task automatic model_reset();
        m_clean = '0;
        m_press = '0;
        m_rel   = '0;
        m_long  = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            dly[ch].delete();
            win[ch].delete();
            for (int i = 0; i < SYNC; i++) dly[ch].push_back(1'b0);
`ifdef DEBOUNCE_LONG_PRESS_EN
            hold[ch] = 0;
`endif
        end
    endtask

    task automatic model_edge();
        for (int ch = 0; ch < NCH; ch++) begin
            bit s;
            bit was;
            bit all_diff;
            s = dly[ch].pop_front();
            dly[ch].push_back(pb[ch]);
            win[ch].push_back(s);
            if (win[ch].size() > STABLE) void'(win[ch].pop_front());
            was = m_clean[ch];
            m_press[ch] = 1'b0;
            m_rel[ch]   = 1'b0;
            m_long[ch]  = 1'b0;
`ifdef DEBOUNCE_LONG_PRESS_EN
            if (!was) begin
                hold[ch] = 0;
            end else if (hold[ch] < LONG) begin
                hold[ch]++;
                m_long[ch] = (hold[ch] == LONG);
            end
`endif
            all_diff = (win[ch].size() == STABLE);
            for (int i = 0; i < win[ch].size(); i++) begin
                if (win[ch][i] == was) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_clean[ch] = !was;
                m_press[ch] = !was;
                m_rel[ch]   = was;
            end
        end
    endtask

    // One clock: advance the model on the edge, drive the next pins/reset,
    // and queue what the DUT should show for the rest of this cycle.
    task automatic cycle(input logic [NCH-1:0] nxt, input logic nrst);
        @(posedge clk);
        #1;
        cyc++;
        if (rst_n) model_edge();
        pb    = nxt;
        rst_n = nrst;
        if (!rst_n) model_reset();
        exp_q.push_back('{clean: m_clean, press: m_press, rel: m_rel, lng: m_long});
    endtask

    // Monitor: scoreboard compare plus event bookkeeping for directed checks.
    logic [NCH-1:0] prev_clean     = '0;
    logic [NCH-1:0] last_press_vec = '0;
    logic [NCH-1:0] last_rel_vec   = '0;
    int rise_at[NCH];
    int press_cnt[NCH];
    int rel_cnt[NCH];
    int long_cnt[NCH];
    int long_at[NCH];
    int press_cycles = 0;
    int rel_cycles   = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check("sb_active_high", 32'({clean_h, press_h, rel_h, long_h}), 32'(mon_exp));
            check("sb_active_low", 32'({clean_l, press_l, rel_l, long_l}), 32'(mon_exp));
            check("press_release_exclusive", 32'(press_h & rel_h), 32'(0));
        end
        for (int ch = 0; ch < NCH; ch++) begin
            if (clean_h[ch] && !prev_clean[ch]) rise_at[ch] = cyc;
            if (press_h[ch]) press_cnt[ch]++;
            if (rel_h[ch]) rel_cnt[ch]++;
            if (long_h[ch]) begin
                long_cnt[ch]++;
                long_at[ch] = cyc;
            end
        end
        if (press_h != '0) begin
            press_cycles++;
            last_press_vec = press_h;
        end
        if (rel_h != '0) begin
            rel_cycles++;
            last_rel_vec = rel_h;
        end
        prev_clean = clean_h;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NCH-1:0] v;
        int k, r, base, base2;
        int widths[3];
        int run[NCH];
        widths = '{3, 4, 5};

        model_reset();
        #1;
        check("reset_clean", 32'(clean_h | clean_l), 32'(0));
        check("reset_pulses", 32'(press_h | rel_h | long_h | press_l | rel_l | long_l), 32'(0));

        repeat (3) cycle(NCH'($urandom), 1'b0);
        cycle('0, 1'b1);
        repeat (12) cycle('0, 1'b1);
        check("no_press_from_reset", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]), 32'(0));

        // Bounce on ch0 then a clean hold applied in the cycle after edge k.
        base = press_cnt[0];
        for (int i = 0; i < 3; i++) begin
            repeat (widths[i]) cycle(4'b0001, 1'b1);
            repeat (2) cycle(4'b0000, 1'b1);
        end
        cycle(4'b0001, 1'b1);
        k = cyc;
        repeat (14) cycle(4'b0001, 1'b1);
        check("bounce_rise_edge", 32'(rise_at[0]), 32'(k + 10));
        check("bounce_press_count", 32'(press_cnt[0] - base), 32'(1));
        base = rel_cnt[0];
        repeat (14) cycle(4'b0000, 1'b1);
        check("bounce_release_count", 32'(rel_cnt[0] - base), 32'(1));
        check("bounce_clean_low", 32'(clean_h[0]), 32'(0));

        // 7-cycle glitch on ch1 must be rejected.
        base  = press_cnt[1];
        base2 = rel_cnt[1];
        repeat (7) cycle(4'b0010, 1'b1);
        repeat (14) cycle(4'b0000, 1'b1);
        check("glitch_no_rise", 32'(rise_at[1]), 32'(0));
        check("glitch_no_press", 32'(press_cnt[1] - base), 32'(0));
        check("glitch_no_release", 32'(rel_cnt[1] - base2), 32'(0));

        // All channels together.
        base = press_cycles;
        repeat (14) cycle(4'b1111, 1'b1);
        check("simul_press_cycles", 32'(press_cycles - base), 32'(1));
        check("simul_press_vec", 32'(last_press_vec), 32'(4'b1111));
        base = rel_cycles;
        repeat (14) cycle(4'b0000, 1'b1);
        check("simul_release_cycles", 32'(rel_cycles - base), 32'(1));
        check("simul_release_vec", 32'(last_rel_vec), 32'(4'b1111));

        // Reset mid-count on ch2 while ch3 is already debounced high.
        repeat (14) cycle(4'b1000, 1'b1);
        cycle(4'b1100, 1'b1);
        repeat (6) cycle(4'b1100, 1'b1);
        cycle(4'b1100, 1'b0);
        #1;
        check("reset_async_clean", 32'(clean_h | clean_l), 32'(0));
        repeat (2) cycle(4'b1100, 1'b0);
        cycle(4'b1100, 1'b1);
        r = cyc;
        repeat (14) cycle(4'b1100, 1'b1);
        check("reset_mid_rise_ch2", 32'(rise_at[2]), 32'(r + 10));
        check("reset_mid_rise_ch3", 32'(rise_at[3]), 32'(r + 10));
        repeat (14) cycle(4'b0000, 1'b1);

        // Long press: 40-cycle hold fires once (if built), 20-cycle hold never.
        base = long_cnt[3];
        repeat (40) cycle(4'b1000, 1'b1);
        repeat (14) cycle(4'b0000, 1'b1);
        check("long_40_count", 32'(long_cnt[3] - base), 32'(LONG_ON));
`ifdef DEBOUNCE_LONG_PRESS_EN
        check("long_40_edge", 32'(long_at[3]), 32'(rise_at[3] + LONG));
`endif
        base = long_cnt[3];
        repeat (20) cycle(4'b1000, 1'b1);
        repeat (14) cycle(4'b0000, 1'b1);
        check("long_20_none", 32'(long_cnt[3] - base), 32'(0));

        // Random bouncing with occasional short resets.
        v = '0;
        for (int ch = 0; ch < NCH; ch++) run[ch] = 0;
        for (int i = 0; i < 1500; i++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (run[ch] == 0) begin
                    v[ch]   = ~v[ch];
                    run[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 50))
                                                          : int'($urandom_range(1, 9));
                end else begin
                    run[ch]--;
                end
            end
            if ($urandom_range(0, 199) == 0) begin
                cycle(v, 1'b0);
                repeat ($urandom_range(0, 2)) cycle(v, 1'b0);
            end
            cycle(v, 1'b1);
        end

        repeat (16) cycle('0, 1'b1);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
